// File: rtl/opcode_encoder.sv
// Registered 8-to-3 opcode encoder with a valid/ready output stage.
// Flags transfers that are not one-hot, keeps a sticky error and a transfer count.
module opcode_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] code,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sticky_err,
  input  logic       err_clr,
  output logic [7:0] xfer_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic [CW-1:0] enc_code;
  logic          enc_err;
  logic          accept;
  logic          xfer;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Highest set bit wins; anything other than exactly one bit set is an error.
  always_comb begin
    enc_code = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (d[i]) enc_code = CW'(i);
    end
    enc_err = (d == '0) || ((d & (d - DW'(1))) != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code      <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      code      <= enc_code;
      out_err   <= enc_err;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Set takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_err <= 1'b0;
    end else if (accept && enc_err) begin
      sticky_err <= 1'b1;
    end else if (err_clr) begin
      sticky_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (xfer) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed, table-driven bench for opcode_encoder with hand-written corner sequences.
module tb_opcode_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] code;
  logic       out_err;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       sticky_err;
  logic       err_clr = 1'b0;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int passed = 0;

  opcode_encoder dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .sticky_err(sticky_err), .err_clr(err_clr), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       iv;
    logic       ordy;
    logic       clr;
    logic       e_rdy;
    logic [2:0] e_code;
    logic       e_err;
    logic       e_ov;
    logic       e_st;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input int c, input int e, input int ov,
                         input int st, input int cnt);
    chk({tag, " code"}, int'(code), c);
    chk({tag, " out_err"}, int'(out_err), e);
    chk({tag, " out_valid"}, int'(out_valid), ov);
    chk({tag, " sticky_err"}, int'(sticky_err), st);
    chk({tag, " xfer_cnt"}, int'(xfer_cnt), cnt);
  endtask

  task automatic drive(input logic [7:0] dd, input logic iv, input logic ordy, input logic clr);
    @(negedge clk);
    d = dd; in_valid = iv; out_ready = ordy; err_clr = clr;
  endtask

  initial begin
    // Sweep of one-hot inputs, back-to-back with out_ready high.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{8'(1 << i), 1'b1, 1'b1, 1'b0, 1'b1, 3'(i), 1'b0, 1'b1, 1'b0, 8'(i)};
    vecs[8]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd8};
    vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'd8};
    vecs[10] = '{8'h28, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 8'd9};
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 8'd10};
    vecs[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'd10};
    vecs[13] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'd10};
    vecs[14] = '{8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 8'd11};
    vecs[15] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'd11};
    vecs[16] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'd11};
    vecs[17] = '{8'hff, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'd11};
    vecs[18] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'd11};
    vecs[19] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 8'd11};
    vecs[20] = '{8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd12};
    vecs[21] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd13};

    #2 rst = 1'b1;
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].d, vecs[i].iv, vecs[i].ordy, vecs[i].clr);
      #1 chk($sformatf("v%0d in_ready", i), int'(in_ready), int'(vecs[i].e_rdy));
      @(posedge clk);
      #1 chk_out($sformatf("v%0d", i), int'(vecs[i].e_code), int'(vecs[i].e_err),
                 int'(vecs[i].e_ov), int'(vecs[i].e_st), int'(vecs[i].e_cnt));
    end

    // Counter wrap: 256 transfers from reset bring xfer_cnt back to 0.
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(8'(1 << (i % 8)), 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      if (i == 0 || i == 100 || i == 255) begin
        chk($sformatf("wrap%0d code", i), int'(code), i % 8);
        chk($sformatf("wrap%0d out_valid", i), int'(out_valid), 1);
        chk($sformatf("wrap%0d cnt", i), int'(xfer_cnt), i);
      end
    end
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 chk_out("wrap drain", 7, 0, 0, 0, 0);
    drive(8'h01, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 chk_out("wrap +1", 0, 0, 0, 0, 1);

    // Asynchronous reset while an erroneous opcode 6 is held.
    drive(8'h41, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_out("pre-rst", 6, 1, 1, 1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("async rst", 0, 0, 0, 0, 0);
    chk("async rst in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    d = 8'h08; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 chk_out("post-rst accept", 3, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
